// File: rtl/uart_rx_word_master_if.sv
// Register-bus link between the RX word master and the UART register slave.
// Read data returns the cycle after the strobe cycle.
interface uart_rx_word_master_if;
    logic        stb;
    logic [1:0]  adr;
    logic        we;
    logic [3:0]  byte_sel;
    logic [31:0] wdat;
    logic [31:0] rdat;

    modport master (
        output stb, adr, we, byte_sel, wdat,
        input  rdat
    );

    modport slave (
        input  stb, adr, we, byte_sel, wdat,
        output rdat
    );
endinterface

// File: rtl/uart_rx_word_master.sv
// Programs the UART, then polls STATUS and drains DATA, packing received bytes
// little-endian into 32-bit words on a valid/ready stream.
module uart_rx_word_master #(
    parameter logic [15:0] BAUD_DIV       = 16'd868,
    parameter logic [1:0]  CTRL_INIT      = 2'b11,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    uart_rx_word_master_if.master        bus,
    output logic [31:0]                  word_o,
    output logic [2:0]                   word_bytes_o,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic                         init_done_o,
    output logic                         frame_err_o
);

    localparam logic [1:0]  ADR_BAUD   = 2'd0;
    localparam logic [1:0]  ADR_CTRL   = 2'd1;
    localparam logic [1:0]  ADR_STATUS = 2'd2;
    localparam logic [1:0]  ADR_DATA   = 2'd3;
    localparam int unsigned RX_EMPTY_BIT  = 3;
    localparam int unsigned FRAME_ERR_BIT = 4;
    localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_INIT_BAUD,
        S_INIT_CTRL,
        S_POLL,
        S_POLL_WAIT,
        S_READ,
        S_READ_WAIT,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] tmo_q, tmo_d;
    logic        init_done_q;
    logic        frame_err_q;

    logic        stb_c;
    logic [1:0]  adr_c;
    logic        we_c;
    logic [3:0]  byte_sel_c;
    logic [31:0] wdat_c;
    logic        valid_c;
    logic        tmo_hit;

    // A limit of zero disables the partial-word flush entirely.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q >= TMO_LIMIT);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        stb_c      = 1'b0;
        adr_c      = 2'd0;
        we_c       = 1'b0;
        byte_sel_c = 4'b0000;
        wdat_c     = 32'd0;
        valid_c    = 1'b0;

        unique case (state_q)
            S_INIT_BAUD: begin
                stb_c      = 1'b1;
                we_c       = 1'b1;
                adr_c      = ADR_BAUD;
                byte_sel_c = 4'b0011;
                wdat_c     = {16'd0, BAUD_DIV};
                state_d    = S_INIT_CTRL;
            end
            S_INIT_CTRL: begin
                stb_c      = 1'b1;
                we_c       = 1'b1;
                adr_c      = ADR_CTRL;
                byte_sel_c = 4'b0001;
                wdat_c     = {30'd0, CTRL_INIT};
                state_d    = S_POLL;
            end
            S_POLL: begin
                stb_c   = 1'b1;
                adr_c   = ADR_STATUS;
                state_d = S_POLL_WAIT;
                if (idx_q != 3'd0 && tmo_q < TMO_LIMIT) tmo_d = tmo_q + 32'd1;
            end
            S_POLL_WAIT: begin
                if (idx_q != 3'd0 && tmo_q < TMO_LIMIT) tmo_d = tmo_q + 32'd1;
                if (!bus.rdat[RX_EMPTY_BIT]) begin
                    state_d = S_READ;
                end else if (idx_q != 3'd0 && tmo_hit) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_READ: begin
                stb_c   = 1'b1;
                adr_c   = ADR_DATA;
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                word_d[{idx_q[1:0], 3'b000} +: 8] = bus.rdat[7:0];
                idx_d   = idx_q + 3'd1;
                tmo_d   = 32'd0;
                state_d = (idx_q == 3'd3) ? S_OUT : S_POLL;
            end
            S_OUT: begin
                valid_c = 1'b1;
                if (word_ready_i) begin
                    word_d  = 32'd0;
                    idx_d   = 3'd0;
                    tmo_d   = 32'd0;
                    state_d = S_POLL;
                end
            end
            default: state_d = S_INIT_BAUD;
        endcase
    end

    // NOTE: reset is synchronous and all state updates use non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT_BAUD;
            word_q      <= 32'd0;
            idx_q       <= 3'd0;
            tmo_q       <= 32'd0;
            init_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            if (state_q == S_INIT_CTRL) init_done_q <= 1'b1;
            if (state_q == S_POLL_WAIT && bus.rdat[FRAME_ERR_BIT]) frame_err_q <= 1'b1;
        end
    end

    // Bus outputs are held quiet while reset is asserted, even though the
    // state register already points at the BAUD write.
    assign bus.stb      = stb_c & ~rst_i;
    assign bus.we       = we_c & ~rst_i;
    assign bus.adr      = rst_i ? 2'd0 : adr_c;
    assign bus.byte_sel = rst_i ? 4'd0 : byte_sel_c;
    assign bus.wdat     = rst_i ? 32'd0 : wdat_c;

    assign word_valid_o = valid_c & ~rst_i;
    assign word_o       = word_q;
    assign word_bytes_o = (state_q == S_OUT) ? idx_q : 3'd0;
    assign init_done_o  = init_done_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_word_master.sv
// Bench for uart_rx_word_master: UART register-slave model with an RX FIFO,
// expected words held in a scoreboard and compared at each stream handshake.
module tb_uart_rx_word_master;

    localparam logic [15:0] BAUD = 16'h0364;

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  bytes;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    uart_rx_word_master_if bus_a ();
    uart_rx_word_master_if bus_b ();

    logic [31:0] word_a, word_b;
    logic [2:0]  bytes_a, bytes_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        init_done_a, init_done_b;
    logic        ferr_a, ferr_b;

    uart_rx_word_master #(.BAUD_DIV(BAUD), .CTRL_INIT(2'b11), .TIMEOUT_CYCLES(20)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus_a),
        .word_o(word_a), .word_bytes_o(bytes_a), .word_valid_o(valid_a),
        .word_ready_i(ready_a), .init_done_o(init_done_a), .frame_err_o(ferr_a)
    );

    uart_rx_word_master #(.BAUD_DIV(BAUD), .CTRL_INIT(2'b11), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus_b),
        .word_o(word_b), .word_bytes_o(bytes_b), .word_valid_o(valid_b),
        .word_ready_i(ready_b), .init_done_o(init_done_b), .frame_err_o(ferr_b)
    );

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        popped;
    logic [7:0]  fifo_a[$];
    logic [7:0]  fifo_b[$];
    int          ferr_req = 0;
    int          ferr_ack = 0;
    int          valid_cnt_a = 0;
    int          valid_cnt_b = 0;
    int          out_stb_a = 0;
    int          unstable_a = 0;
    logic        held_a = 1'b0;
    logic [31:0] held_word_a = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [2:0] n);
        exp_t e;
        e.word  = w;
        e.bytes = n;
        sb.push_back(e);
    endtask

    task automatic wait_sb_empty(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // UART register slave A: STATUS bit3 = rx_empty, bit4 = one-shot frame error.
    always @(posedge clk_i) begin
        bus_a.rdat <= 32'd0;
        if (bus_a.stb && !bus_a.we) begin
            if (bus_a.adr == 2'd2) begin
                bus_a.rdat <= {27'd0, (ferr_req != ferr_ack), (fifo_a.size() == 0), 3'd0};
                ferr_ack   <= ferr_req;
            end else if (bus_a.adr == 2'd3 && fifo_a.size() != 0) begin
                bus_a.rdat <= {24'd0, fifo_a.pop_front()};
            end
        end
    end

    always @(posedge clk_i) begin
        bus_b.rdat <= 32'd0;
        if (bus_b.stb && !bus_b.we) begin
            if (bus_b.adr == 2'd2) begin
                bus_b.rdat <= {27'd0, 1'b0, (fifo_b.size() == 0), 3'd0};
            end else if (bus_b.adr == 2'd3 && fifo_b.size() != 0) begin
                bus_b.rdat <= {24'd0, fifo_b.pop_front()};
            end
        end
    end

    // Stream monitor A: scoreboard compare on handshake, stability under backpressure.
    always @(negedge clk_i) begin
        if (!rst_i && valid_a) begin
            valid_cnt_a++;
            if (bus_a.stb) out_stb_a++;
            if (held_a && word_a !== held_word_a) unstable_a++;
            held_a      = !ready_a;
            held_word_a = word_a;
            if (ready_a) begin
                checks++;
                assert (sb.size() != 0)
                else begin
                    failures++;
                    $error("FAIL unexpected_word observed=0x%0h expected=none", word_a);
                end
                if (sb.size() != 0) begin
                    popped = sb.pop_front();
                    check("word", word_a, popped.word);
                    check("word_bytes", 32'(bytes_a), 32'(popped.bytes));
                end
            end
        end else begin
            held_a = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && valid_b) valid_cnt_b++;
    end

    initial begin
        int n;
        rst_i   = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b1;
        repeat (3) @(negedge clk_i);

        check("rst_stb", 32'(bus_a.stb), 32'd0);
        check("rst_we", 32'(bus_a.we), 32'd0);
        check("rst_byte_sel", 32'(bus_a.byte_sel), 32'd0);
        check("rst_dat", bus_a.wdat, 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_word", word_a, 32'd0);
        check("rst_init_done", 32'(init_done_a), 32'd0);
        check("rst_frame_err", 32'(ferr_a), 32'd0);

        fifo_b.push_back(8'h01);
        fifo_b.push_back(8'h02);

        // Release: cycle 0 BAUD write, cycle 1 CTRL write, cycle 2 first poll.
        rst_i = 1'b0;
        #1;
        check("baud_stb", 32'(bus_a.stb), 32'd1);
        check("baud_we", 32'(bus_a.we), 32'd1);
        check("baud_adr", 32'(bus_a.adr), 32'd0);
        check("baud_byte_sel", 32'(bus_a.byte_sel), 32'h3);
        check("baud_dat", bus_a.wdat, 32'h364);
        @(negedge clk_i);
        check("ctrl_stb", 32'(bus_a.stb), 32'd1);
        check("ctrl_adr", 32'(bus_a.adr), 32'd1);
        check("ctrl_byte_sel", 32'(bus_a.byte_sel), 32'h1);
        check("ctrl_dat", bus_a.wdat, 32'h3);
        check("ctrl_init_done", 32'(init_done_a), 32'd0);
        @(negedge clk_i);
        check("poll_init_done", 32'(init_done_a), 32'd1);
        check("poll_stb", 32'(bus_a.stb), 32'd1);
        check("poll_we", 32'(bus_a.we), 32'd0);
        check("poll_adr", 32'(bus_a.adr), 32'd2);
        check("poll_byte_sel", 32'(bus_a.byte_sel), 32'd0);

        // One full word with the consumer always ready.
        ready_a     = 1'b1;
        valid_cnt_a = 0;
        fifo_a.push_back(8'h78);
        fifo_a.push_back(8'h56);
        fifo_a.push_back(8'h34);
        fifo_a.push_back(8'h12);
        expect_word(32'h12345678, 3'd4);
        wait_sb_empty(200, "full_word_timeout");
        repeat (5) @(negedge clk_i);
        check("full_word_valid_cycles", 32'(valid_cnt_a), 32'd1);

        // Eight bytes under 50 cycles of backpressure.
        ready_a    = 1'b0;
        out_stb_a  = 0;
        unstable_a = 0;
        for (int i = 1; i <= 8; i++) fifo_a.push_back(8'(i));
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        n = 0;
        while (!valid_a && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("bp_valid_seen", 32'(valid_a), 32'd1);
        repeat (50) @(negedge clk_i);
        check("bp_valid_held", 32'(valid_a), 32'd1);
        check("bp_word_held", word_a, 32'h04030201);
        check("bp_fifo_left", 32'(fifo_a.size()), 32'd4);
        ready_a = 1'b1;
        wait_sb_empty(200, "bp_words_timeout");
        check("bp_stb_in_out", 32'(out_stb_a), 32'd0);
        check("bp_word_unstable", 32'(unstable_a), 32'd0);

        // Partial word flushed after 20 idle polling cycles.
        fifo_a.push_back(8'hAA);
        fifo_a.push_back(8'hBB);
        expect_word(32'h0000BBAA, 3'd2);
        wait_sb_empty(300, "partial_timeout");

        // Timeout disabled: two bytes then a long idle stretch never flush.
        repeat (10000) @(negedge clk_i);
        check("no_flush_valid", 32'(valid_cnt_b), 32'd0);
        check("no_flush_fifo_drained", 32'(fifo_b.size()), 32'd0);

        // Frame error on one STATUS sample; the byte is still delivered.
        ferr_req++;
        fifo_a.push_back(8'hDE);
        fifo_a.push_back(8'hAD);
        fifo_a.push_back(8'hBE);
        fifo_a.push_back(8'hEF);
        expect_word(32'hEFBEADDE, 3'd4);
        wait_sb_empty(200, "ferr_word_timeout");
        check("frame_err_set", 32'(ferr_a), 32'd1);
        repeat (30) @(negedge clk_i);
        check("frame_err_sticky", 32'(ferr_a), 32'd1);

        // Reset mid-word: partial discarded, init writes reissued.
        fifo_a.push_back(8'h11);
        n = 0;
        while (fifo_a.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("midword_byte_read", 32'(fifo_a.size()), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst2_frame_err", 32'(ferr_a), 32'd0);
        check("rst2_init_done", 32'(init_done_a), 32'd0);
        valid_cnt_a = 0;
        rst_i = 1'b0;
        #1;
        check("rst2_baud_stb", 32'(bus_a.stb), 32'd1);
        check("rst2_baud_adr", 32'(bus_a.adr), 32'd0);
        check("rst2_baud_dat", bus_a.wdat, 32'h364);
        @(negedge clk_i);
        check("rst2_ctrl_adr", 32'(bus_a.adr), 32'd1);
        repeat (100) @(negedge clk_i);
        check("rst2_partial_dropped", 32'(valid_cnt_a), 32'd0);
        check("rst2_init_done_again", 32'(init_done_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
